// File: rtl/rggen_register_bus_arbiter.sv
// ---------------------------------------------------------------------------
// rggen_register_bus_arbiter
//
// Round-robin arbiter that shares one register-block request bus among HOSTS
// bus masters. One host request is captured at a time, held on the register
// bus until i_register_ready, and answered with a registered one-cycle
// response pulse to the granted host.
//
// Optional feature (macro RGGEN_BUS_ARBITER_TIMEOUT_EN):
//   When defined, an access that stays in BUSY for TIMEOUT_CYCLES cycles
//   without ready is terminated with status 2'b10 and read data 0. When
//   undefined, BUSY waits indefinitely and TIMEOUT_CYCLES is ignored.
//
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_host_valid            per-host request, held until its ready pulse
//   i_host_access           per-host access (2 bits each, bit0 = write)
//   i_host_address          per-host address
//   i_host_write_data       per-host write data
//   i_host_strobe           per-host bit-enable mask
//   o_host_ready            one-hot, one-cycle completion pulse
//   o_host_status           response status, broadcast, qualified by ready
//   o_host_read_data        response data, broadcast, qualified by ready
//   o_grant                 one-hot current owner, 0 while idle
//   o_register_*            registered downstream request
//   i_register_ready        downstream completion
//   i_register_status       downstream status
//   i_register_read_data    downstream read data
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module rggen_register_bus_arbiter #(
  parameter int HOSTS          = 2,
  parameter int ADDRESS_WIDTH  = 8,
  parameter int BUS_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [HOSTS-1:0]              i_host_valid,
  input  logic [2*HOSTS-1:0]            i_host_access,
  input  logic [ADDRESS_WIDTH*HOSTS-1:0] i_host_address,
  input  logic [BUS_WIDTH*HOSTS-1:0]    i_host_write_data,
  input  logic [BUS_WIDTH*HOSTS-1:0]    i_host_strobe,
  output logic [HOSTS-1:0]              o_host_ready,
  output logic [1:0]                    o_host_status,
  output logic [BUS_WIDTH-1:0]          o_host_read_data,
  output logic [HOSTS-1:0]              o_grant,
  output logic                          o_register_valid,
  output logic [1:0]                    o_register_access,
  output logic [ADDRESS_WIDTH-1:0]      o_register_address,
  output logic [BUS_WIDTH-1:0]          o_register_write_data,
  output logic [BUS_WIDTH-1:0]          o_register_strobe,
  input  logic                          i_register_ready,
  input  logic [1:0]                    i_register_status,
  input  logic [BUS_WIDTH-1:0]          i_register_read_data
);

  localparam int IW = (HOSTS > 1) ? $clog2(HOSTS) : 1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] BUSY    = 2'd1;
  localparam logic [1:0] RESPOND = 2'd2;

  // Elaboration-time parameter sanity checks.
  if (HOSTS < 2) begin : g_bad_hosts
    $error("HOSTS must be at least 2");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..65535");
  end

  logic [1:0]    state;
  logic [IW-1:0] last;   // host served most recently
  logic [IW-1:0] owner;  // host currently granted

  logic                     pick_found;
  logic [IW-1:0]            pick;
  logic [HOSTS-1:0]         pick_onehot;
  logic [1:0]               pick_access;
  logic [ADDRESS_WIDTH-1:0] pick_address;
  logic [BUS_WIDTH-1:0]     pick_write_data;
  logic [BUS_WIDTH-1:0]     pick_strobe;

  // Round-robin search: start at last+1 and wrap, first requester wins.
  // NOTE: every signal gets a default before the loop so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    int idx;
    pick_found      = 1'b0;
    pick            = '0;
    pick_onehot     = '0;
    pick_access     = '0;
    pick_address    = '0;
    pick_write_data = '0;
    pick_strobe     = '0;
    for (int i = 1; i <= HOSTS; i++) begin
      idx = (int'(last) + i) % HOSTS;
      if (!pick_found && i_host_valid[idx]) begin
        pick_found       = 1'b1;
        pick             = IW'(idx);
        pick_onehot[idx] = 1'b1;
        pick_access      = i_host_access[2*idx +: 2];
        pick_address     = i_host_address[ADDRESS_WIDTH*idx +: ADDRESS_WIDTH];
        pick_write_data  = i_host_write_data[BUS_WIDTH*idx +: BUS_WIDTH];
        pick_strobe      = i_host_strobe[BUS_WIDTH*idx +: BUS_WIDTH];
      end
    end
  end

`ifdef RGGEN_BUS_ARBITER_TIMEOUT_EN
  logic [15:0] busy_count;
  logic        busy_expired;
  assign busy_expired = (busy_count == 16'(TIMEOUT_CYCLES - 1));
`endif

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state                 <= IDLE;
      last                  <= IW'(HOSTS - 1);
      owner                 <= '0;
      o_host_ready          <= '0;
      o_host_status         <= 2'b00;
      o_host_read_data      <= '0;
      o_grant               <= '0;
      o_register_valid      <= 1'b0;
      o_register_access     <= '0;
      o_register_address    <= '0;
      o_register_write_data <= '0;
      o_register_strobe     <= '0;
`ifdef RGGEN_BUS_ARBITER_TIMEOUT_EN
      busy_count            <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            owner                 <= pick;
            o_grant               <= pick_onehot;
            o_register_valid      <= 1'b1;
            o_register_access     <= pick_access;
            o_register_address    <= pick_address;
            o_register_write_data <= pick_write_data;
            o_register_strobe     <= pick_strobe;
            state                 <= BUSY;
`ifdef RGGEN_BUS_ARBITER_TIMEOUT_EN
            busy_count            <= '0;
`endif
          end
        end
        BUSY: begin
          // Ready takes precedence over an expiring watchdog.
          if (i_register_ready) begin
            o_host_status    <= i_register_status;
            o_host_read_data <= i_register_read_data;
            o_host_ready     <= o_grant;
            o_register_valid <= 1'b0;
            state            <= RESPOND;
          end
`ifdef RGGEN_BUS_ARBITER_TIMEOUT_EN
          else if (busy_expired) begin
            o_host_status    <= 2'b10;
            o_host_read_data <= '0;
            o_host_ready     <= o_grant;
            o_register_valid <= 1'b0;
            state            <= RESPOND;
          end else begin
            busy_count <= busy_count + 16'd1;
          end
`endif
        end
        RESPOND: begin
          o_host_ready <= '0;
          o_grant      <= '0;
          last         <= owner;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
